// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// stopwatch_ctrl : SS.cc stopwatch control (run/pause/lap/overflow) with
//                  4-digit BCD count and free-running display scan clock.
// Revision 1.0   : initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl #(
  parameter int TICK_DIV = 1000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btnStartStop,
  input  logic        btnLapClr,
  output logic [15:0] BCD,
  output logic        scanClk,
  output logic        running,
  output logic        lapHeld,
  output logic        overflow
);

  localparam int c_presc_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_scan_w  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_presc_w-1:0] c_tick_max = c_presc_w'(TICK_DIV - 1);
  localparam logic [c_scan_w-1:0]  c_scan_max = c_scan_w'(SCAN_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_OVF   = 3'd4
  } state_t;

  state_t                r_state;
  logic [c_presc_w-1:0]  r_presc;
  logic [c_scan_w-1:0]   r_scan_cnt;
  logic [15:0]           r_count;
  logic [15:0]           r_lap;
  logic [15:0]           r_bcd;
  logic                  r_scan_clk;
  logic                  r_running;
  logic                  r_lap_held;
  logic                  r_overflow;

  logic                  w_tick;
  logic                  w_at_max;
  logic [15:0]           w_count_adv;

  // Ripple-carry BCD increment: a 9 digit wraps to 0 and carries upward.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  assign w_tick      = ((r_state == ST_RUN) || (r_state == ST_LAP)) && (r_presc == c_tick_max);
  assign w_at_max    = (r_count == 16'h9999);
  assign w_count_adv = w_tick ? bcd_inc(r_count) : r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_presc    <= '0;
      r_count    <= 16'h0000;
      r_lap      <= 16'h0000;
      r_bcd      <= 16'h0000;
      r_running  <= 1'b0;
      r_lap_held <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (btnStartStop) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN, ST_LAP: begin
          if (w_tick && w_at_max) begin
            r_state    <= ST_OVF;
            r_presc    <= '0;
            r_lap      <= 16'h0000;
            r_bcd      <= r_count;
            r_running  <= 1'b0;
            r_lap_held <= 1'b0;
            r_overflow <= 1'b1;
          end else begin
            r_count <= w_count_adv;
            // The pausing edge does not advance the prescaler, so the
            // fraction seen on resume is exactly what was accumulated.
            if (w_tick) begin
              r_presc <= '0;
            end else if (!btnStartStop) begin
              r_presc <= r_presc + 1'b1;
            end
            if (btnStartStop) begin
              r_state    <= ST_PAUSE;
              r_bcd      <= w_count_adv;
              r_running  <= 1'b0;
              r_lap_held <= 1'b0;
            end else if (btnLapClr && (r_state == ST_RUN)) begin
              r_state    <= ST_LAP;
              r_lap      <= r_count;
              r_bcd      <= r_count;
              r_lap_held <= 1'b1;
            end else if (btnLapClr) begin
              r_state    <= ST_RUN;
              r_bcd      <= w_count_adv;
              r_lap_held <= 1'b0;
            end else begin
              r_bcd <= (r_state == ST_LAP) ? r_lap : w_count_adv;
            end
          end
        end
        ST_PAUSE: begin
          if (btnStartStop) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end else if (btnLapClr) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_count <= 16'h0000;
            r_lap   <= 16'h0000;
            r_bcd   <= 16'h0000;
          end
        end
        ST_OVF: begin
          if (!btnStartStop && btnLapClr) begin
            r_state    <= ST_IDLE;
            r_presc    <= '0;
            r_count    <= 16'h0000;
            r_bcd      <= 16'h0000;
            r_overflow <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_presc    <= '0;
          r_count    <= 16'h0000;
          r_lap      <= 16'h0000;
          r_bcd      <= 16'h0000;
          r_running  <= 1'b0;
          r_lap_held <= 1'b0;
          r_overflow <= 1'b0;
        end
      endcase
    end
  end

  // Display scan clock runs regardless of the stopwatch state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_scan_clk <= 1'b0;
    end else if (r_scan_cnt == c_scan_max) begin
      r_scan_cnt <= '0;
      r_scan_clk <= ~r_scan_clk;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  assign BCD      = r_bcd;
  assign scanClk  = r_scan_clk;
  assign running  = r_running;
  assign lapHeld  = r_lap_held;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000000, clk cycles per 10 ms count tick (100 MHz clk).
REQ-002 Parameter SCAN_DIV, default 50000, clk cycles per half-period of scanClk.
REQ-003 Port clk, input, 1, single system clock; all state updates on posedge.
REQ-004 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port btnStartStop, input, 1, single-cycle synchronous pulse (already debounced).
REQ-006 Port btnLapClr, input, 1, single-cycle synchronous pulse (already debounced).
REQ-007 Port BCD, output, 16, displayed time SS.cc: [15:12] tens-s, [11:8] s, [7:4] tenths, [3:0] hundredths; feeds the 4-digit display driver (decimal point after seconds digit).
REQ-008 Port scanClk, output, 1, registered square wave for the display multiplexer clock.
REQ-009 Port running, output, 1, high in RUN or LAP.
REQ-010 Port lapHeld, output, 1, high in LAP.
REQ-011 Port overflow, output, 1, high in OVF.

Function
REQ-012 States IDLE, RUN, PAUSE, LAP, OVF; one transition max per cycle; transitions registered on the edge that samples the pulse.
REQ-013 IDLE: btnStartStop -> RUN; btnLapClr ignored.
REQ-014 RUN: btnStartStop -> PAUSE; btnLapClr -> LAP, latching the live count into lap register on the same edge.
REQ-015 LAP: counting continues; btnStartStop -> PAUSE; btnLapClr -> RUN.
REQ-016 PAUSE: btnStartStop -> RUN; btnLapClr -> IDLE, clearing count and prescaler to 0.
REQ-017 OVF: btnStartStop ignored; btnLapClr -> IDLE with clear.
REQ-018 Both pulses in same cycle: btnStartStop acts, btnLapClr ignored.
REQ-019 Prescaler counts 0..TICK_DIV-1 only in RUN/LAP; holds in PAUSE (fraction preserved); zero in IDLE/OVF.
REQ-020 Tick = prescaler at TICK_DIV-1 in RUN/LAP; count increments by 1 hundredth on that edge, prescaler wraps to 0.
REQ-021 Count is 4-digit BCD; each digit 0-9, carry ripple on the same edge (x9 -> (x+1)0); never holds a non-BCD digit.
REQ-022 Tick at count 99.99: count holds 99.99, state -> OVF (also from LAP, lap register discarded).
REQ-023 Tick coinciding with btnStartStop in RUN: increment applies, then PAUSE.
REQ-024 BCD = lap register in LAP, else live count; registered, no combinational path from inputs.
REQ-025 scanClk toggles every SCAN_DIV cycles, free-running in all states, independent of state machine.

Reset
REQ-026 rst_n low: state IDLE, count 0000, lap register 0000, prescaler 0, scan divider 0, BCD 16'h0000, scanClk 0, running/lapHeld/overflow 0; immediate, without clk.
REQ-027 Reset deassertion: first state change only on a pulse sampled at a later posedge; reset mid-RUN discards count.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-028 Reset, btnStartStop, 40 cycles -> BCD 16'h0010, running=1.
REQ-029 Run to 00.09, one more tick -> 16'h0010; run to 09.99, tick -> 16'h1000.
REQ-030 RUN at 00.05, btnLapClr -> BCD frozen 16'h0005, lapHeld=1 while live count advances; btnLapClr again -> BCD shows live count, lapHeld=0.
REQ-031 btnStartStop at prescaler 2, wait 20 cycles, btnStartStop -> next tick exactly 2 cycles later (fraction preserved); PAUSE + btnLapClr -> BCD 0000, IDLE.
REQ-032 Run to 99.99, tick -> BCD 16'h9999, overflow=1, running=0, btnStartStop ignored; btnLapClr -> 0000, IDLE.
REQ-033 Both pulses same cycle in RUN -> PAUSE, BCD live, lapHeld=0; rst_n low mid-RUN -> all outputs 0 before next posedge; scanClk period 4 cycles throughout.
